// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between the CPU datapath and the front-panel loader.
// One access in flight; priority follows CPU run state, bounded by per-side starvation counters.
module mem_arbiter #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cpustate,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        pnl_req,
  input  logic        pnl_we,
  input  logic [15:0] pnl_addr,
  input  logic [7:0]  pnl_wdata,
  output logic        pnl_ack,
  output logic [7:0]  pnl_rdata,
  input  logic [7:0]  mem_rdata,
  output logic        read,
  output logic        write,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        owner,
  output logic        busy
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned WW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   cpu_wait_q, cpu_wait_d;
  logic [WW-1:0]   pnl_wait_q, pnl_wait_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            pnl_ack_q, pnl_ack_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   pnl_rdata_q, pnl_rdata_d;

  logic            cpu_hi;
  logic            grant_pnl;
  logic            sel_we;

  // Next-state, grant and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_wait_d  = cpu_wait_q;
    pnl_wait_d  = pnl_wait_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    cpu_ack_d   = 1'b0;
    pnl_ack_d   = 1'b0;
    cpu_rdata_d = '0;
    pnl_rdata_d = '0;
    cpu_hi      = (cpustate == 2'b11);
    grant_pnl   = 1'b0;
    sel_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || pnl_req) begin
          // A starved loser at MAX_WAIT overrides the mode-based priority
          if (cpu_req && pnl_req) begin
            grant_pnl = cpu_hi ? (pnl_wait_q == WW'(MAX_WAIT))
                               : (cpu_wait_q != WW'(MAX_WAIT));
          end else begin
            grant_pnl = pnl_req;
          end
          sel_we  = grant_pnl ? pnl_we : cpu_we;
          owner_d = grant_pnl;
          we_d    = sel_we;
          addr_d  = grant_pnl ? pnl_addr : cpu_addr;
          data_d  = grant_pnl ? pnl_wdata : cpu_wdata;
          cnt_d   = '0;
          busy_d  = 1'b1;
          read_d  = ~sel_we;
          write_d = sel_we;
          state_d = ACCESS;
          if (grant_pnl) begin
            pnl_wait_d = '0;
            if (cpu_req && (cpu_wait_q != WW'(MAX_WAIT))) cpu_wait_d = cpu_wait_q + WW'(1);
          end else begin
            cpu_wait_d = '0;
            if (pnl_req && (pnl_wait_q != WW'(MAX_WAIT))) pnl_wait_d = pnl_wait_q + WW'(1);
          end
        end
      end

      ACCESS: begin
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          state_d = DONE;
          if (owner_q) begin
            pnl_ack_d   = 1'b1;
            pnl_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = we_q ? '0 : mem_rdata;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          read_d  = ~we_q;
          write_d = we_q;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpu_wait_q  <= '0;
      pnl_wait_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      pnl_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      pnl_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_wait_q  <= cpu_wait_d;
      pnl_wait_q  <= pnl_wait_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      read_q      <= read_d;
      write_q     <= write_d;
      cpu_ack_q   <= cpu_ack_d;
      pnl_ack_q   <= pnl_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      pnl_rdata_q <= pnl_rdata_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign cpu_ack   = cpu_ack_q;
  assign pnl_ack   = pnl_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign pnl_rdata = pnl_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the CPU datapath and the front-panel loader/checker, so that memory can be loaded or inspected through the panel while the CPU is stopped or running. It sits between the CPU, the panel logic and `memory`, on the memory clock. Requests are level-held handshakes; one access is in flight at a time. Priority follows the CPU run state and is bounded by a starvation counter.

## Interface
Parameters:
- `MEM_LAT`, 2: cycles `read`/`write` are held per access (≥1)
- `MAX_WAIT`, 4: lost arbitrations before the low-priority requester is forced to win (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: memory clock
- `rst` in 1: synchronous reset, active-high
- `cpustate` in 2: CPU state; `2'b11` = run, any other value = stopped/load/check
- `cpu_req` in 1: CPU access request, held until `cpu_ack`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in 16: CPU address
- `cpu_wdata` in 8: CPU write data
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_rdata` out 8: read data, valid while `cpu_ack`=1
- `pnl_req`, `pnl_we`, `pnl_addr[15:0]`, `pnl_wdata[7:0]`, `pnl_ack`, `pnl_rdata[7:0]`: same meaning, panel side
- `mem_rdata` in 8: RAM read data
- `read` out 1: RAM read strobe
- `write` out 1: RAM write strobe
- `addr` out 16: RAM address
- `data` out 8: RAM write data
- `owner` out 1: 0 = CPU, 1 = panel (current or last grant)
- `busy` out 1: access in flight

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample the requests. If none is pending, stay in IDLE. If exactly one is pending, grant it. If both are pending, the high-priority side wins: the CPU when `cpustate`=`2'b11`, otherwise the panel. The exception is when the loser's wait counter equals `MAX_WAIT`; then the loser wins.
- On grant: latch `we`, address and write data of the winner into `addr`/`data`, set `owner`, and go to ACCESS. Requester inputs are ignored after the grant.
- Wait counter (3+ bits, saturating at `MAX_WAIT`), one per side: increments when that side is pending and loses; clears when that side is granted. It is not touched when that side is not pending.
- ACCESS: `read`=~we or `write`=we held for exactly `MAX_WAIT`-independent `MEM_LAT` cycles, with `addr`/`data` stable throughout. An internal counter counts 0..`MEM_LAT`-1, then the FSM goes to DONE.
- DONE: for one cycle, pulse the owner's `*_ack` and present `mem_rdata` on the owner's `*_rdata` (registered on entering DONE for reads; reads return 0 for writes). Strobes are low. Then return to IDLE.
- Requesters drop `req` on the edge that samples `ack`. A `req` still high in the next IDLE cycle is a new request.
- `cpustate` is only evaluated in IDLE; a mode change mid-access does not affect that access.
- Only one strobe is ever high at a time; `read` and `write` are never both 1.

## Timing
- Reset values: state IDLE; `read`=`write`=0; `addr`=0; `data`=0; `cpu_ack`=`pnl_ack`=0; `cpu_rdata`=`pnl_rdata`=0; `owner`=0; `busy`=0; both wait counters 0.
- `rst` mid-access: abort immediately. Strobes drop on the next edge, no ack is issued, and the requester must re-request.
- Latency: request seen in IDLE at cycle N; strobe high in N+1..N+`MEM_LAT`; ack in N+`MEM_LAT`+1; IDLE in N+`MEM_LAT`+2. Back-to-back throughput is one access per `MEM_LAT`+2 cycles.
- `busy`=1 in ACCESS and DONE.
- Simultaneous requests while a counter is at `MAX_WAIT` and the mode favours the other side: the counter wins.

## Test plan
- Single CPU read, `MEM_LAT`=2, `cpu_addr`=16'h0012, RAM[0x12]=8'hA5 -> `read` high for 2 cycles, `cpu_ack` 3 cycles after the request with `cpu_rdata`=8'hA5; `pnl_ack` stays 0.
- Panel write with `cpustate`=2'b00, `pnl_addr`=16'h0040, data 8'h3C -> `write` held 2 cycles with `addr`=0x0040 and `data`=0x3C, `pnl_ack` pulses; a following CPU read of 0x40 returns 8'h3C.
- Both requesting continuously with `cpustate`=2'b11, `MAX_WAIT`=4 -> grant sequence CPU, CPU, CPU, CPU, PNL, CPU, and so on (panel every 5th); with `cpustate`=2'b01 the roles are mirrored.
- `cpustate` changes from 2'b11 to 2'b00 during a CPU access with the panel pending -> the CPU access completes and is acked, then the panel is granted next.
- `rst` asserted in the second ACCESS cycle -> strobes 0 on the next edge, no ack, all outputs at reset values, wait counters 0.
- `req` held high through the ack cycle -> a second access starts in the next IDLE cycle (two acks, spaced `MEM_LAT`+2=4 cycles apart).
